ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Parametrised multi-cycle integer multiply/divide execute unit implementing the RV32M/RV64M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits in the execute stage beside the single-cycle ALU and receives operands after forwarding selection.
- Stalls upstream with o_busy while iterating.
- Returns a registered result with destination tag for the EX/MEM register.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64.
MUL_STEP, 1, multiplier bits retired per cycle; legal values 1, 2, 4; must divide XLEN.

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_vld  input  1  operation request valid
i_md_op  input  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
i_op1  input  XLEN  rs1 operand (forwarded)
i_op2  input  XLEN  rs2 operand (forwarded)
i_rd_waddr  input  5  destination register tag
i_flush  input  1  squash in-flight operation (branch mispredict / trap)
o_busy  output  1  unit not idle; upstream holds the instruction in EX
o_vld  output  1  result valid, one-cycle pulse
o_res  output  XLEN  result
o_rd_waddr  output  5  destination tag accompanying o_res

Behaviour:
- Reset (i_rst_n low, asynchronous): state IDLE, o_busy=0, o_vld=0, o_res=0, o_rd_waddr=0. Internal accumulators cleared. Reset mid-operation abandons the operation; no o_vld follows.
- FSM states: IDLE, MUL, DIV, DONE. o_busy = (state != IDLE), registered-state decode.
- Accept: only in IDLE with i_vld=1 and i_flush=0. The edge latches i_md_op, i_rd_waddr, and operand magnitudes/sign flags.
  - i_vld in MUL, DIV or DONE is ignored; upstream must hold while o_busy=1.
- Multiply:
  - Operand signedness by op. MUL and MULH: both signed. MULHSU: op1 signed, op2 unsigned. MULHU: both unsigned.
  - Compute |a|*|b| by shift-add, MUL_STEP bits per cycle, for N = XLEN/MUL_STEP cycles in state MUL, into a 2*XLEN product.
  - Negate the product if the operand signs differ (signed operands only).
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
- Divide:
  - Restoring divide, 1 quotient bit per cycle, XLEN cycles in state DIV, on magnitudes.
  - Quotient is negated if the signs differ (DIV only). Remainder takes the sign of the dividend (REM).
- Special cases resolved at accept, skipping MUL/DIV and going straight to DONE:
  - Divisor 0: quotient all-ones; remainder = op1.
  - Signed overflow (op1 = most-negative, op2 = -1): DIV returns most-negative; REM returns 0.
- DONE: lasts exactly one cycle with o_vld=1; o_res and o_rd_waddr are valid. Next state is IDLE.
  - o_res and o_rd_waddr hold their values after DONE until the next DONE.
- Latency, with acceptance on edge 0:
  - Multiply: o_vld high in cycle N+1.
  - Divide: o_vld high in cycle XLEN+1.
  - Special cases: o_vld high in cycle 1.
  - Back-to-back operations: the next accept is possible in the cycle after DONE.
- Flush:
  - i_flush=1 in any state forces IDLE at the next edge; o_vld stays 0 and o_res/o_rd_waddr are not updated.
  - Flush has priority over accept in the same cycle.
  - Flush during DONE suppresses nothing: o_vld is already asserted that cycle; next state IDLE.
- Width rules:
  - All arithmetic is modulo 2^XLEN except the 2*XLEN product.
  - Negation is two's complement.
  - Magnitude of most-negative is represented with an XLEN+1-bit intermediate or unsigned wrap.

Test Plan:
- XLEN=32, MUL_STEP=1: MUL 7 × 0xFFFFFFFD (-3) accepted cycle 0 -> o_busy 1 cycles 1–33, o_vld only in cycle 33, o_res=0xFFFFFFEB, o_rd_waddr echoes input.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF. MULHU 0xFFFFFFFF × 2 -> 0x00000001. Repeat with MUL_STEP=4: o_vld in cycle 9.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. o_vld in cycle 33.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0. Each o_vld in cycle 1.
- Flush in cycle 10 of a DIV -> IDLE next edge, no o_vld, o_res unchanged. Flush and i_vld same cycle in IDLE -> not accepted. i_vld pulsed while busy -> ignored.
- Assert i_rst_n=0 asynchronously mid-MUL (between edges) -> o_busy/o_vld/o_res/o_rd_waddr immediately 0. After release, a new MUL 3×4 -> 12 with nominal latency.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M/RV64M multiply/divide execute unit.
//
// Multiplies use shift-add on operand magnitudes, MUL_STEP multiplier bits per
// cycle. Divides use a restoring algorithm, one quotient bit per cycle. Results
// are sign-corrected on the final iteration and registered on entry to DONE.
// Divide-by-zero and signed overflow are resolved at accept and go straight to DONE.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_vld, i_md_op        request valid, funct3 operation select
//   i_op1, i_op2          rs1 / rs2 operands (forwarded)
//   i_rd_waddr            destination register tag
//   i_flush               squash any in-flight operation
//   o_busy                unit not idle; upstream holds the instruction
//   o_vld                 one-cycle result-valid pulse
//   o_res, o_rd_waddr     result and its destination tag; held until next result
module ex_muldiv #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_vld,
    input  logic [2:0]      i_md_op,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic [4:0]      i_rd_waddr,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_vld,
    output logic [XLEN-1:0] o_res,
    output logic [4:0]      o_rd_waddr
);

    localparam int unsigned NMul = XLEN / MUL_STEP;
    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] MulLast = CntW'(NMul - 1);
    localparam logic [CntW-1:0] DivLast = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e              state_q, state_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;     // mul: {hi, multiplier}; div: {rem, quotient}
    logic [XLEN-1:0]     a_q, a_d;         // multiplicand or divisor magnitude
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic                neg_q, neg_d;     // product / quotient needs negation
    logic                neg_rem_q, neg_rem_d;
    logic [4:0]          tag_q, tag_d;     // tag of the operation in flight
    logic [XLEN-1:0]     res_q, res_d;
    logic [4:0]          rd_q, rd_d;

    // Operand decode at accept
    logic            op1_signed, op2_signed, sign1, sign2, is_div, div_zero, div_ovf;
    logic [XLEN-1:0] mag1, mag2;

    always_comb begin
        is_div     = i_md_op[2];
        op1_signed = is_div ? ~i_md_op[0] : (i_md_op[1:0] != 2'b11);
        op2_signed = is_div ? ~i_md_op[0] : ~i_md_op[1];
        sign1      = op1_signed & i_op1[XLEN-1];
        sign2      = op2_signed & i_op2[XLEN-1];
        // Negating the most-negative value wraps to itself, which is the correct magnitude
        mag1       = sign1 ? -i_op1 : i_op1;
        mag2       = sign2 ? -i_op2 : i_op2;
        div_zero   = (i_op2 == '0);
        div_ovf    = ~i_md_op[0] & (i_op1 == MinNeg) & (i_op2 == '1);
    end

    // One shift-add iteration: add a * (low MUL_STEP multiplier bits) to the high half,
    // then shift the whole product register right by MUL_STEP.
    logic [XLEN+MUL_STEP-1:0] pp;
    logic [2*XLEN-1:0]        mul_next, prod;
    logic [XLEN-1:0]          mul_res;

    always_comb begin
        pp = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]};
        for (int j = 0; j < int'(MUL_STEP); j++) begin
            if (acc_q[j]) begin
                pp = pp + ({{MUL_STEP{1'b0}}, a_q} << j);
            end
        end
        mul_next = {pp, acc_q[XLEN-1:MUL_STEP]};
        prod     = neg_q ? -mul_next : mul_next;
        mul_res  = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // One restoring-divide iteration: shift in the next dividend bit, trial-subtract.
    logic [XLEN:0]     rem_sh, diff;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   quo, rem, div_res;

    always_comb begin
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff     = rem_sh - {1'b0, a_q};
        div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        quo      = div_next[XLEN-1:0];
        rem      = div_next[2*XLEN-1:XLEN];
        div_res  = op_q[1] ? (neg_rem_q ? -rem : rem) : (neg_q ? -quo : quo);
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        a_d       = a_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        tag_d     = tag_q;
        res_d     = res_q;
        rd_d      = rd_q;
        if (i_flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_vld) begin
                        op_d      = i_md_op[1:0];
                        tag_d     = i_rd_waddr;
                        neg_d     = sign1 ^ sign2;
                        neg_rem_d = sign1;
                        cnt_d     = '0;
                        if (is_div && (div_zero || div_ovf)) begin
                            state_d = StDone;
                            rd_d    = i_rd_waddr;
                            if (div_zero) res_d = i_md_op[1] ? i_op1 : '1;
                            else          res_d = i_md_op[1] ? '0 : MinNeg;
                        end else if (is_div) begin
                            state_d = StDiv;
                            acc_d   = {{XLEN{1'b0}}, mag1};
                            a_d     = mag2;
                        end else begin
                            state_d = StMul;
                            acc_d   = {{XLEN{1'b0}}, mag2};
                            a_d     = mag1;
                        end
                    end
                end
                StMul: begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == MulLast) begin
                        state_d = StDone;
                        res_d   = mul_res;
                        rd_d    = tag_q;
                    end
                end
                StDiv: begin
                    acc_d = div_next;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == DivLast) begin
                        state_d = StDone;
                        res_d   = div_res;
                        rd_d    = tag_q;
                    end
                end
                StDone: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            a_q       <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            tag_q     <= '0;
            res_q     <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            tag_q     <= tag_d;
            res_q     <= res_d;
            rd_q      <= rd_d;
        end
    end

    assign o_busy     = (state_q != StIdle);
    assign o_vld      = (state_q == StDone);
    assign o_res      = res_q;
    assign o_rd_waddr = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: XLEN=32 with MUL_STEP=1 (u_dut) and MUL_STEP=4
// (u_dut4) driven by the same stimulus.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [4:0]  rd_waddr = '0;
    logic        flush = 1'b0;

    logic        busy, out_vld, busy4, out_vld4;
    logic [31:0] res, res4;
    logic [4:0]  rd_out, rd_out4;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    logic [31:0] last_res;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32), .MUL_STEP(1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld), .i_md_op(md_op), .i_op1(op1),
        .i_op2(op2), .i_rd_waddr(rd_waddr), .i_flush(flush), .o_busy(busy),
        .o_vld(out_vld), .o_res(res), .o_rd_waddr(rd_out)
    );

    ex_muldiv #(.XLEN(32), .MUL_STEP(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld), .i_md_op(md_op), .i_op1(op1),
        .i_op2(op2), .i_rd_waddr(rd_waddr), .i_flush(flush), .o_busy(busy4),
        .o_vld(out_vld4), .o_res(res4), .o_rd_waddr(rd_out4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, accepted on the following edge (cycle 0 -> edge 0).
    // lat/lat4 are the cycles in which o_vld must first rise for each instance.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input logic [31:0] exp, input int lat, input int lat4);
        int cyc, seen1, seen4;
        logic busy_ok;
        logic [31:0] r1, r4;
        logic [4:0] t1;
        @(negedge clk);
        vld = 1'b1; md_op = op; op1 = a; op2 = b; rd_waddr = tag;
        @(posedge clk);
        #1;
        vld = 1'b0;
        cyc = 1; seen1 = 0; seen4 = 0; busy_ok = 1'b1;
        r1 = '0; r4 = '0; t1 = '0;
        while (cyc <= lat + 4) begin
            if (out_vld && seen1 == 0) begin seen1 = cyc; r1 = res; t1 = rd_out; end
            if (out_vld4 && seen4 == 0) begin seen4 = cyc; r4 = res4; end
            if (!busy && cyc <= lat) busy_ok = 1'b0;
            if (seen1 != 0 && seen4 != 0) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({name, " vld_cycle"}, 64'(seen1), 64'(lat));
        chk({name, " res"}, {32'd0, r1}, {32'd0, exp});
        chk({name, " tag"}, {59'd0, t1}, {59'd0, tag});
        chk({name, " busy"}, {63'd0, busy_ok}, 64'd1);
        chk({name, " vld_cycle_s4"}, 64'(seen4), 64'(lat4));
        chk({name, " res_s4"}, {32'd0, r4}, {32'd0, exp});
        @(posedge clk);
        #1;
        chk({name, " vld_drop"}, {63'd0, out_vld}, 64'd0);
        chk({name, " idle"}, {63'd0, busy}, 64'd0);
        chk({name, " hold"}, {32'd0, res}, {32'd0, exp});
        last_res = exp;
    endtask

    initial begin
        int cyc;
        bit seen;
        // Reset state
        #12;
        chk("rst busy", {63'd0, busy}, 64'd0);
        chk("rst vld", {63'd0, out_vld}, 64'd0);
        chk("rst res", {32'd0, res}, 64'd0);
        chk("rst tag", {59'd0, rd_out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Multiplies
        do_op("MUL", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 33, 9);
        do_op("MULH", 3'd1, 32'h80000000, 32'h80000000, 5'd6, 32'h40000000, 33, 9);
        do_op("MULHSU", 3'd2, 32'hFFFFFFFF, 32'd2, 5'd7, 32'hFFFFFFFF, 33, 9);
        do_op("MULHU", 3'd3, 32'hFFFFFFFF, 32'd2, 5'd8, 32'h00000001, 33, 9);

        // Divides
        do_op("DIV", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFD, 33, 33);
        do_op("REM", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF, 33, 33);
        do_op("DIVU", 3'd5, 32'd100, 32'd7, 5'd11, 32'd14, 33, 33);
        do_op("REMU", 3'd7, 32'd100, 32'd7, 5'd12, 32'd2, 33, 33);

        // Special cases
        do_op("DIVU0", 3'd5, 32'd5, 32'd0, 5'd13, 32'hFFFFFFFF, 1, 1);
        do_op("REM0", 3'd6, 32'd5, 32'd0, 5'd14, 32'd5, 1, 1);
        do_op("DIVOVF", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1, 1);
        do_op("REMOVF", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0, 1, 1);

        // Flush in cycle 10 of a divide
        @(negedge clk);
        vld = 1'b1; md_op = 3'd5; op1 = 32'd1000; op2 = 32'd3; rd_waddr = 5'd20;
        @(posedge clk);
        #1;
        vld = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        chk("flush pre busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush busy", {63'd0, busy}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_vld) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("flush no vld", {63'd0, seen}, 64'd0);
        chk("flush res", {32'd0, res}, {32'd0, last_res});
        chk("flush tag", {59'd0, rd_out}, 64'd16);

        // Flush and request together in IDLE
        @(negedge clk);
        vld = 1'b1; flush = 1'b1; md_op = 3'd0; op1 = 32'd2; op2 = 32'd2; rd_waddr = 5'd21;
        @(posedge clk);
        #1;
        vld = 1'b0; flush = 1'b0;
        chk("flush+vld busy", {63'd0, busy}, 64'd0);

        // Request while busy is ignored
        @(negedge clk);
        vld = 1'b1; md_op = 3'd0; op1 = 32'd6; op2 = 32'd7; rd_waddr = 5'd22;
        @(posedge clk);
        #1;
        vld = 1'b0;
        for (int i = 1; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        vld = 1'b1; md_op = 3'd5; op1 = 32'd9; op2 = 32'd0; rd_waddr = 5'd23;
        @(posedge clk);
        #1;
        vld = 1'b0;
        cyc = 6;
        while (!out_vld && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("ignore cycle", 64'(cyc), 64'd33);
        chk("ignore res", {32'd0, res}, 64'd42);
        chk("ignore tag", {59'd0, rd_out}, 64'd22);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-multiply
        @(negedge clk);
        vld = 1'b1; md_op = 3'd0; op1 = 32'd11; op2 = 32'd13; rd_waddr = 5'd24;
        @(posedge clk);
        #1;
        vld = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst busy", {63'd0, busy}, 64'd0);
        chk("arst vld", {63'd0, out_vld}, 64'd0);
        chk("arst res", {32'd0, res}, 64'd0);
        chk("arst tag", {59'd0, rd_out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_vld) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("arst no vld", {63'd0, seen}, 64'd0);
        do_op("MUL after rst", 3'd0, 32'd3, 32'd4, 5'd25, 32'd12, 33, 9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
